// File: rtl/rc4_prga_decrypt_param_if.sv
// Bus bundle for the RC4 PRGA/decrypt engine: start/done handshake, S-RAM port,
// ciphertext ROM port and decrypted-message RAM port.
interface rc4_prga_decrypt_param_if #(
  parameter int MSG_AW = 5
);
  logic              start;
  logic              done;
  logic              msg_ok;
  logic [7:0]        s_q;
  logic [7:0]        s_address;
  logic [7:0]        s_data;
  logic              s_wren;
  logic [7:0]        msg_q;
  logic [MSG_AW-1:0] msg_address;
  logic [MSG_AW-1:0] out_address;
  logic [7:0]        out_data;
  logic              out_wren;

  modport master (
    input  start, s_q, msg_q,
    output done, msg_ok, s_address, s_data, s_wren,
           msg_address, out_address, out_data, out_wren
  );

  modport slave (
    output start, s_q, msg_q,
    input  done, msg_ok, s_address, s_data, s_wren,
           msg_address, out_address, out_data, out_wren
  );
endinterface

// File: rtl/rc4_prga_decrypt_param.sv
// RC4 PRGA/decrypt engine: walks a pre-filled S-RAM, XORs keystream into ciphertext.
// Define RC4_PLAINTEXT_CHECK_EN to abort early on a non-[a-z ] plaintext byte.
module rc4_prga_decrypt_param #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5,
  parameter int RD_LAT  = 3
) (
  input  logic clk,
  input  logic reset,
  rc4_prga_decrypt_param_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, INC_I, RD_I, WAIT_I, CAP_I, RD_J, WAIT_J, WR_J,
    WR_I, RD_F, WAIT_F, CAP_F, WAIT_M, CAP_M, XOR_WR, DONE
  } state_t;

  localparam logic [3:0]        LAT_LAST = 4'((RD_LAT == 0) ? 0 : RD_LAT - 1);
  localparam logic [MSG_AW-1:0] K_LAST   = MSG_AW'(MSG_LEN - 1);

  state_t            state_q, state_d;
  logic [3:0]        wcnt;
  logic [7:0]        i, j, si, sj, f, c, s_addr;
  logic [MSG_AW-1:0] k, m_addr;
  logic              ok;
  logic [7:0]        pt;
  logic              lat_done;
  logic              in_wait;
  logic              last_byte;

  assign pt        = c ^ f;
  assign lat_done  = (wcnt == LAT_LAST);
  assign in_wait   = (state_q == WAIT_I) || (state_q == WAIT_J) ||
                     (state_q == WAIT_F) || (state_q == WAIT_M);

`ifdef RC4_PLAINTEXT_CHECK_EN
  logic pt_valid;
  assign pt_valid  = ((pt >= 8'h61) && (pt <= 8'h7A)) || (pt == 8'h20);
  assign last_byte = (k == K_LAST) || !pt_valid;
`else
  assign last_byte = (k == K_LAST);
`endif

  assign bus.s_address   = s_addr;
  assign bus.msg_address = m_addr;
  assign bus.out_address = k;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture of each read is folded into the following action so one byte costs
  // 10 cycles plus the four RD_LAT wait windows.
  always_comb begin
    state_d        = state_q;
    bus.s_wren     = 1'b0;
    bus.s_data     = '0;
    bus.out_wren   = 1'b0;
    bus.out_data   = '0;
    bus.done       = 1'b0;
    bus.msg_ok     = 1'b0;
    case (state_q)
      IDLE:   if (bus.start) state_d = INC_I;
      INC_I:  state_d = RD_I;
      RD_I:   state_d = (RD_LAT == 0) ? CAP_I : WAIT_I;
      WAIT_I: if (lat_done) state_d = CAP_I;
      CAP_I:  state_d = RD_J;
      RD_J:   state_d = (RD_LAT == 0) ? WR_J : WAIT_J;
      WAIT_J: if (lat_done) state_d = WR_J;
      WR_J: begin
        bus.s_wren = 1'b1;
        bus.s_data = si;
        state_d    = WR_I;
      end
      WR_I: begin
        bus.s_wren = 1'b1;
        bus.s_data = sj;
        state_d    = RD_F;
      end
      RD_F:   state_d = (RD_LAT == 0) ? CAP_F : WAIT_F;
      WAIT_F: if (lat_done) state_d = CAP_F;
      CAP_F:  state_d = (RD_LAT == 0) ? CAP_M : WAIT_M;
      WAIT_M: if (lat_done) state_d = CAP_M;
      CAP_M:  state_d = XOR_WR;
      XOR_WR: begin
        bus.out_wren = 1'b1;
        bus.out_data = pt;
        state_d      = last_byte ? DONE : INC_I;
      end
      DONE: begin
        bus.done   = 1'b1;
        bus.msg_ok = ok;
        if (!bus.start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt   <= '0;
      i      <= '0;
      j      <= '0;
      si     <= '0;
      sj     <= '0;
      f      <= '0;
      c      <= '0;
      s_addr <= '0;
      k      <= '0;
      m_addr <= '0;
      ok     <= 1'b0;
    end else begin
      wcnt <= in_wait ? wcnt + 4'd1 : '0;
      case (state_q)
        IDLE: if (bus.start) begin
          i  <= '0;
          j  <= '0;
          k  <= '0;
          ok <= 1'b1;
        end
        INC_I:  i <= i + 8'd1;
        RD_I:   s_addr <= i;
        CAP_I: begin
          si <= bus.s_q;
          j  <= j + bus.s_q;
        end
        RD_J:   s_addr <= j;
        // S[j] is still on s_q here; the address moves to i for the second write.
        WR_J: begin
          sj     <= bus.s_q;
          s_addr <= i;
        end
        RD_F:   s_addr <= si + sj;
        CAP_F: begin
          f      <= bus.s_q;
          m_addr <= k;
        end
        CAP_M:  c <= bus.msg_q;
        XOR_WR: begin
          if (!last_byte) k <= k + 1'b1;
`ifdef RC4_PLAINTEXT_CHECK_EN
          if (!pt_valid) ok <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt_param.sv
// Randomized bench for rc4_prga_decrypt_param: latency-accurate memory models plus an
// array-based RC4 reference tracking S across runs.
module tb_rc4_prga_decrypt_param;
  localparam int MSG_LEN = 16;
  localparam int MSG_AW  = 4;
  localparam int RD_LAT  = 2;
  localparam int BYTE_CY = 10 + 4 * RD_LAT;
  localparam int BUDGET  = MSG_LEN * BYTE_CY + 40;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rc4_prga_decrypt_param_if #(.MSG_AW(MSG_AW)) bus ();

  rc4_prga_decrypt_param #(
    .MSG_LEN(MSG_LEN),
    .MSG_AW (MSG_AW),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Memories: q shows the addressed word RD_LAT clocks after the address is driven.
  logic [7:0] s_mem  [256];
  logic [7:0] s_load [256];
  logic       load_s = 1'b0;
  logic [7:0] s_pipe [RD_LAT];
  logic [7:0] rom    [MSG_LEN];
  logic [7:0] m_pipe [RD_LAT];

  assign bus.s_q   = s_pipe[RD_LAT-1];
  assign bus.msg_q = m_pipe[RD_LAT-1];

  always @(posedge clk) begin
    s_pipe[0] <= s_mem[bus.s_address];
    m_pipe[0] <= rom[bus.msg_address];
    for (int p = 1; p < RD_LAT; p++) begin
      s_pipe[p] <= s_pipe[p-1];
      m_pipe[p] <= m_pipe[p-1];
    end
    if (load_s) s_mem <= s_load;
    else if (bus.s_wren) s_mem[bus.s_address] <= bus.s_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int              wr_cnt = 0;
  logic [MSG_AW-1:0] wr_addr [1024];
  logic [7:0]      wr_data [1024];
  int              wr_cyc  [1024];
  always @(negedge clk) begin
    if (bus.out_wren === 1'b1 && wr_cnt < 1024) begin
      wr_addr[wr_cnt] <= bus.out_address;
      wr_data[wr_cnt] <= bus.out_data;
      wr_cyc[wr_cnt]  <= cyc;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference RC4 state
  byte unsigned ms  [256];
  byte unsigned tmp [256];
  byte unsigned ks  [MSG_LEN];

  task automatic keystream(input int n);
    int ii = 0, jj = 0;
    byte unsigned t;
    for (int x = 0; x < n; x++) begin
      ii      = (ii + 1) % 256;
      jj      = (jj + int'(tmp[ii])) % 256;
      t       = tmp[ii];
      tmp[ii] = tmp[jj];
      tmp[jj] = t;
      ks[x]   = tmp[(int'(tmp[ii]) + int'(tmp[jj])) % 256];
    end
  endtask

  function automatic bit printable(input byte unsigned b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  task automatic set_identity();
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
  endtask

  task automatic set_ksa(input int k0, input int k1, input int k2);
    int key[3];
    int jj = 0;
    byte unsigned t;
    key = '{k0, k1, k2};
    set_identity();
    for (int x = 0; x < 256; x++) begin
      jj     = (jj + int'(ms[x]) + key[x % 3]) % 256;
      t      = ms[x];
      ms[x]  = ms[jj];
      ms[jj] = t;
    end
  endtask

  task automatic push_s();
    for (int x = 0; x < 256; x++) s_load[x] = ms[x];
    @(negedge clk) load_s = 1'b1;
    @(negedge clk) load_s = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    check({tag, "_done"},     32'(bus.done),        0);
    check({tag, "_msg_ok"},   32'(bus.msg_ok),      0);
    check({tag, "_s_addr"},   32'(bus.s_address),   0);
    check({tag, "_s_data"},   32'(bus.s_data),      0);
    check({tag, "_s_wren"},   32'(bus.s_wren),      0);
    check({tag, "_msg_addr"}, 32'(bus.msg_address), 0);
    check({tag, "_out_addr"}, 32'(bus.out_address), 0);
    check({tag, "_out_data"}, 32'(bus.out_data),    0);
    check({tag, "_out_wren"}, 32'(bus.out_wren),    0);
  endtask

  // mode 0: ciphertext zero, 1: [a-z] plaintext, 2: one bad byte, 3: random ciphertext
  task automatic run(input string tag, input int mode, input bit hold);
    byte unsigned pt[MSG_LEN];
    int  exp_n, base, lat, got_n, bad, mism;
    bit  exp_ok;
    tmp = ms;
    keystream(MSG_LEN);
    bad = $urandom_range(MSG_LEN - 1, 0);
    for (int x = 0; x < MSG_LEN; x++) begin
      case (mode)
        0:       pt[x] = ks[x];
        1:       pt[x] = 8'($urandom_range(8'h7A, 8'h61));
        2:       pt[x] = (x == bad) ? 8'($urandom_range(31, 0)) : 8'($urandom_range(8'h7A, 8'h61));
        default: pt[x] = 8'($urandom);
      endcase
      rom[x] = pt[x] ^ ks[x];
    end
    exp_n  = MSG_LEN;
    exp_ok = 1'b1;
`ifdef RC4_PLAINTEXT_CHECK_EN
    for (int x = 0; x < MSG_LEN; x++) begin
      if (!printable(pt[x])) begin
        exp_n  = x + 1;
        exp_ok = 1'b0;
        break;
      end
    end
`endif
    base = wr_cnt;
    @(negedge clk) bus.start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.done !== 1'b1 && lat < BUDGET);
    check({tag, "_latency"}, lat, exp_n * BYTE_CY + 1);
    check({tag, "_msg_ok"}, 32'(bus.msg_ok), 32'(exp_ok));
    got_n = wr_cnt - base;
    check({tag, "_nwrites"}, got_n, exp_n);
    for (int x = 0; x < exp_n && x < got_n; x++) begin
      check($sformatf("%s_addr%0d", tag, x), 32'(wr_addr[base+x]), x);
      check($sformatf("%s_data%0d", tag, x), 32'(wr_data[base+x]), 32'(pt[x]));
      if (x > 0)
        check($sformatf("%s_period%0d", tag, x), wr_cyc[base+x] - wr_cyc[base+x-1], BYTE_CY);
    end
    check({tag, "_out_addr_final"}, 32'(bus.out_address), exp_n - 1);
    tmp = ms;
    keystream(exp_n);
    ms = tmp;
    mism = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== ms[x]) mism++;
    check({tag, "_s_final_mismatches"}, mism, 0);
    if (hold) begin
      repeat (8) @(negedge clk);
      check({tag, "_done_held"}, 32'(bus.done), 1);
      check({tag, "_no_restart"}, wr_cnt - base, exp_n);
    end
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, "_done_clear"}, 32'(bus.done), 0);
    check({tag, "_msg_ok_clear"}, 32'(bus.msg_ok), 0);
  endtask

  initial begin
    int base0, n;
    reset     = 1'b0;
    bus.start = 1'b0;
    for (int x = 0; x < MSG_LEN; x++) rom[x] = '0;
    set_identity();
    push_s();
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    reset = 1'b1;

    // Identity S with zero ciphertext: plaintext is the raw keystream 02,05,07,...
    base0 = wr_cnt;
    run("ident_zero", 0, 1'b0);
    check("ident_b0", 32'(wr_data[base0]), 32'h02);
`ifndef RC4_PLAINTEXT_CHECK_EN
    check("ident_b1", 32'(wr_data[base0+1]), 32'h05);
    check("ident_b2", 32'(wr_data[base0+2]), 32'h07);
`endif

    set_identity();
    push_s();
    run("ident_text", 1, 1'b0);

    set_ksa(0, 0, 1);
    push_s();
    run("ksa001_rand", 3, 1'b1);
    run("cont_badbyte", 2, 1'b0);

    for (int r = 0; r < 4; r++) begin
      set_ksa($urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0));
      push_s();
      run($sformatf("rnd%0d", r), $urandom_range(3, 0), 1'b0);
    end

    // Reset in the middle of byte 10; the next run must start again from k=0, i=1.
    set_ksa(7, 3, 9);
    push_s();
    tmp = ms;
    keystream(MSG_LEN);
    for (int x = 0; x < MSG_LEN; x++) rom[x] = ks[x] ^ 8'($urandom_range(8'h7A, 8'h61));
    base0 = wr_cnt;
    @(negedge clk) bus.start = 1'b1;
    n = 0;
    while (wr_cnt - base0 < 10 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("midrun_reached_byte10", wr_cnt - base0, 10);
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_quiet("midrun_reset");
    bus.start = 1'b0;
    @(negedge clk) reset = 1'b1;
    set_ksa(7, 3, 9);
    push_s();
    run("after_reset", 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rc4_prga_decrypt_param.md
Name: rc4_prga_decrypt_param

Overview:
- Parametrised RC4 PRGA/decrypt engine for the next-generation cracking datapath.
- Runs after the KSA block has filled the shared S-RAM (256x8). Reads ciphertext from the encrypted-message ROM and writes plaintext to the decrypted-message RAM.
- Generalises message length and memory read latency over the previous stage, and adds a start/done handshake that can be re-armed.
- Optionally adds an early-abort plaintext validity check, used by the key-search controller.

Parameters:
MSG_LEN, 32, number of message bytes processed (1..2^MSG_AW)
MSG_AW, 5, address width of the message ROM and the decrypted RAM
RD_LAT, 3, wait cycles between driving a RAM/ROM address and sampling its q (0..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low (0 = reset)
start  input  1  level request; run begins when sampled high in IDLE
done  output  1  run finished; held high until start is low
msg_ok  output  1  valid only while done=1; 1 = every byte passed (or check disabled)
s_q  input  8  S-RAM read data
s_address  output  8  S-RAM address
s_data  output  8  S-RAM write data
s_wren  output  1  S-RAM write enable
msg_q  input  8  ciphertext ROM data
msg_address  output  MSG_AW  ciphertext ROM address
out_address  output  MSG_AW  decrypted RAM address
out_data  output  8  decrypted RAM write data
out_wren  output  1  decrypted RAM write enable

Behaviour:
- Reset (async assert, sync release): state=IDLE; i=j=0; k=0; done=0; msg_ok=0.
  - All address/data outputs are 0; s_wren=0; out_wren=0.
  - Reset mid-run aborts immediately. S-RAM contents are left as-is; the controller must re-run KSA.
- All arithmetic on i, j and the keystream address is mod 256 (8-bit wrap). k counts 0..MSG_LEN-1.
- WAIT_x states each last exactly RD_LAT cycles; RD_LAT=0 skips them.
- States and transitions:
  - IDLE: when start=1, clear i, j, k to 0 -> INC_I.
  - INC_I: i <= i+1 -> RD_I.
  - RD_I: s_address <= i -> WAIT_I -> CAP_I (si <= s_q).
  - J_UPD: j <= j+si -> RD_J.
  - RD_J: s_address <= j -> WAIT_J -> CAP_J (sj <= s_q).
  - WR_J: s_wren=1, s_address=j, s_data=si -> WR_I.
  - WR_I: s_wren=1, s_address=i, s_data=sj -> RD_F.
  - RD_F: s_wren=0, s_address <= si+sj -> WAIT_F -> CAP_F (f <= s_q).
  - RD_M: msg_address <= k -> WAIT_M -> CAP_M (c <= msg_q).
  - XOR_WR: out_wren=1 for exactly one cycle, out_address=k, out_data=c^f -> NEXT.
  - NEXT: if k==MSG_LEN-1 -> DONE, else k <= k+1 -> INC_I.
  - DONE: done=1, msg_ok=1; when start=0 -> IDLE with done=0.
- When i==j, the swap writes the same value twice; this is legal and produces no corruption.
- Cycles per byte = 10 + 4*RD_LAT. s_wren is high only in WR_J and WR_I.
- start is ignored outside IDLE. Deasserting start mid-run does not abort.
- A new run does not reinitialise S. Running again continues on the permuted S; this is the caller's responsibility.

Optional Feature:
RC4_PLAINTEXT_CHECK_EN
- Defined: in XOR_WR, if c^f is neither 8'h61..8'h7A nor 8'h20, the write is still performed, then go to DONE with msg_ok=0 (early abort, k frozen at the failing index).
- Undefined: no check; msg_ok is always 1 in DONE and all MSG_LEN bytes are written.

Test Plan:
- Identity S (S[x]=x), ciphertext all 8'h00, MSG_LEN=3, RD_LAT=3 -> out bytes 02,05,07 at addresses 0,1,2; final S[2]=03, S[3]=05, S[5]=02; done rises after 3*22 cycles plus IDLE/DONE overhead.
- Same setup with ciphertext 61^02, 62^05, 63^07 -> out "abc"; msg_ok=1 with the check enabled.
- Check enabled, ciphertext byte1 = 8'h05 (plaintext 00) -> byte1 written, done=1, msg_ok=0, out_address stops at 1, no write to address 2.
- Assert reset low during WAIT_J of byte 10 -> all outputs 0 in the same cycle; next start restarts at k=0, i=1.
- Default params, S from KSA with key 00 00 01 vs a software model -> all 32 bytes match; start held high -> done stays high, no restart until start goes low then high.
- RD_LAT=0 and MSG_LEN=1 -> exactly one out_wren pulse; byte period = 10 cycles.
